bin_search_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bin_search engine (64-bit sorted data, 8-bit key, en/rdy/valid handshake) between NUM_REQ requesters. It accepts a request, latches the operands, pulses the engine enable, and tracks the engine's busy/done handshake. It returns the engine result, tagged with the requester ID, on a shared response bus. It sits between the requesting clients and bin_search.

---
 rtl/bin_search_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_bin_search_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_search_arbiter.sv
// Round-robin arbiter that shares one bin_search engine among NUM_REQ requesters.
// Optional macro BSARB_TIMEOUT_EN adds a WAIT_DONE watchdog and the err_timeout port.
module bin_search_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ID_W      = 2,
   parameter int BUSY_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*64-1:0] req_data,
   input  logic [NUM_REQ*8-1:0]  req_key,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [63:0]           eng_data,
   output logic [7:0]            eng_X,
   output logic                  eng_en,
   input  logic                  eng_rdy,
   input  logic [7:0]            eng_out,
   input  logic                  eng_valid,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [7:0]            rsp_out,
   output logic                  rsp_found,
   output logic                  busy,
   output logic                  err
`ifdef BSARB_TIMEOUT_EN
   ,
   output logic                  err_timeout
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } state_t;

   localparam int              BW_W       = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
   localparam logic [BW_W-1:0] LP_BW_LAST = BW_W'(BUSY_WAIT - 1);
   localparam logic [ID_W:0]   LP_NREQ    = (ID_W + 1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LP_LAST    = ID_W'(NUM_REQ - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_id;
   logic [BW_W-1:0]     r_bw_cnt;
   logic [63:0]         r_eng_data;
   logic [7:0]          r_eng_x;
   logic                r_eng_en;
   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [7:0]          r_rsp_out;
   logic                r_rsp_found;
   logic                r_busy;
   logic                r_err;

   logic [ID_W:0]       w_sum;
   logic [ID_W-1:0]     w_idx;
   logic [ID_W-1:0]     w_win;
   logic                w_any;
   logic                w_grant;
   logic                w_done;
   logic                w_bw_expire;
   logic                w_dn_expire;

   // Round-robin search: first pending requester at or after the pointer, wrapping.
   always_comb begin
      w_any = 1'b0;
      w_win = {ID_W{1'b0}};
      w_sum = {(ID_W + 1){1'b0}};
      w_idx = {ID_W{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (ID_W + 1)'(k);
         w_idx = (w_sum >= LP_NREQ) ? ID_W'(w_sum - LP_NREQ) : ID_W'(w_sum);
         w_win = req_valid[w_idx] ? w_idx : w_win;
         w_any = w_any | req_valid[w_idx];
      end
      w_grant   = (r_state == ST_IDLE) && eng_rdy && w_any && rst_n;
      req_ready = w_grant ? ({{(NUM_REQ - 1){1'b0}}, 1'b1} << w_win) : {NUM_REQ{1'b0}};
   end

`ifdef BSARB_TIMEOUT_EN
   logic [15:0] r_tmo_cnt;
   logic        r_err_timeout;

   // Watchdog on the engine's done handshake; the strobe lines up with RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt     <= 16'd0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_timeout <= w_dn_expire;
         if (r_state == ST_WAIT_DONE) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
         end else begin
            r_tmo_cnt <= 16'd0;
         end
      end
   end

   assign err_timeout = r_err_timeout;
`endif

   // Next-state logic and the completion/expiry qualifiers.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_bw_expire = 1'b0;
      w_dn_expire = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_nxt = ST_ISSUE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!eng_rdy) begin
               w_state_nxt = ST_WAIT_DONE;
            end else if (r_bw_cnt == LP_BW_LAST) begin
               w_state_nxt = ST_RESP;
               w_bw_expire = 1'b1;
            end else begin
               w_state_nxt = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (eng_rdy) begin
               w_state_nxt = ST_RESP;
               w_done      = 1'b1;
            end
`ifdef BSARB_TIMEOUT_EN
            else if (r_tmo_cnt == 16'd1023) begin
               w_state_nxt = ST_RESP;
               w_dn_expire = 1'b1;
            end
`endif
            else begin
               w_state_nxt = ST_WAIT_DONE;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register, operand/result capture and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= {ID_W{1'b0}};
         r_id        <= {ID_W{1'b0}};
         r_bw_cnt    <= {BW_W{1'b0}};
         r_eng_data  <= 64'd0;
         r_eng_x     <= 8'd0;
         r_eng_en    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= {ID_W{1'b0}};
         r_rsp_out   <= 8'd0;
         r_rsp_found <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_eng_en    <= w_grant;
         r_rsp_valid <= (w_state_nxt == ST_RESP);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_err       <= r_err | w_bw_expire | w_dn_expire;
         if (w_grant) begin
            r_eng_data <= req_data[64*w_win +: 64];
            r_eng_x    <= req_key[8*w_win +: 8];
            r_id       <= w_win;
            r_ptr      <= (w_win == LP_LAST) ? {ID_W{1'b0}} : w_win + ID_W'(1);
         end
         if (r_state == ST_ISSUE) begin
            r_bw_cnt <= {BW_W{1'b0}};
         end else if ((r_state == ST_WAIT_BUSY) && (w_state_nxt == ST_WAIT_BUSY)) begin
            r_bw_cnt <= r_bw_cnt + BW_W'(1);
         end
         if (w_state_nxt == ST_RESP) begin
            r_rsp_id <= r_id;
         end
         // A failed handshake reports a miss; the watchdog path flags it with 8'hFF.
         if (w_done) begin
            r_rsp_out   <= eng_out;
            r_rsp_found <= eng_valid;
         end else if (w_bw_expire) begin
            r_rsp_out   <= 8'd0;
            r_rsp_found <= 1'b0;
         end else if (w_dn_expire) begin
            r_rsp_out   <= 8'hFF;
            r_rsp_found <= 1'b0;
         end
      end
   end

   assign eng_data  = r_eng_data;
   assign eng_X     = r_eng_x;
   assign eng_en    = r_eng_en;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_out   = r_rsp_out;
   assign rsp_found = r_rsp_found;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: tb/tb_bin_search_arbiter.sv
// Randomised bench for bin_search_arbiter with a behavioural engine stub and a
// transaction-level round-robin reference model.
module tb_bin_search_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int ID_W      = 2;
   localparam int BUSY_WAIT = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*64-1:0] req_data;
   logic [NUM_REQ*8-1:0]  req_key;
   logic [NUM_REQ-1:0]    req_ready;
   logic [63:0]           eng_data;
   logic [7:0]            eng_X;
   logic                  eng_en;
   logic                  eng_rdy;
   logic [7:0]            eng_out;
   logic                  eng_valid;
   logic                  rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [7:0]            rsp_out;
   logic                  rsp_found;
   logic                  busy;
   logic                  err;
`ifdef BSARB_TIMEOUT_EN
   logic                  err_timeout;
`endif

   always #5 clk = ~clk;

   bin_search_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .BUSY_WAIT(BUSY_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_key(req_key),
      .req_ready(req_ready), .eng_data(eng_data), .eng_X(eng_X), .eng_en(eng_en),
      .eng_rdy(eng_rdy), .eng_out(eng_out), .eng_valid(eng_valid), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_found(rsp_found), .busy(busy), .err(err)
`ifdef BSARB_TIMEOUT_EN
      , .err_timeout(err_timeout)
`endif
   );

   typedef struct {
      int          id;
      logic [63:0] data;
      logic [7:0]  key;
      int          gcyc;
      int          kind;   // engine behaviour at grant: 0 normal, 1 never busy, 2 never done
   } rec_t;

   int checks = 0;
   int errors = 0;

   rec_t            q[$];
   int              glog[$];
   int              cyc = 0;
   int              ngrant = 0;
   int              ref_ptr;
   bit              ref_idle;
   bit              ref_issue;
   bit              ref_err;
   int              hold_id;
   logic [7:0]      hold_out;
   logic            hold_found;
   bit              rand_mode = 1'b0;
   logic [NUM_REQ-1:0]    nxt_valid;
   logic [NUM_REQ*64-1:0] nxt_data;
   logic [NUM_REQ*8-1:0]  nxt_key;

   int              eng_mode = 0;
   int              eng_cnt = 0;
   int              eng_lat_cfg = 0;
   int              busy_len = 0;
   logic [8:0]      eng_res;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int ref_winner(input logic [NUM_REQ-1:0] v, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // Reference lookup: linear scan for the key.
   function automatic logic [8:0] ref_search(input logic [63:0] d, input logic [7:0] k);
      for (int i = 0; i < 8; i++) begin
         if (d[8*i +: 8] == k) return {1'b1, 8'(i)};
      end
      return 9'd0;
   endfunction

   // Engine stub lookup: binary search over the ascending bytes.
   function automatic logic [8:0] eng_search(input logic [63:0] d, input logic [7:0] k);
      int lo = 0;
      int hi = 7;
      int mid;
      while (lo <= hi) begin
         mid = (lo + hi) / 2;
         if (d[8*mid +: 8] == k) return {1'b1, 8'(mid)};
         else if (d[8*mid +: 8] < k) lo = mid + 1;
         else hi = mid - 1;
      end
      return 9'd0;
   endfunction

   task automatic gen_slot(input int i);
      logic [63:0] d;
      int v;
      v = $urandom_range(0, 40);
      for (int b = 0; b < 8; b++) begin
         v = v + $urandom_range(1, 25);
         d[8*b +: 8] = 8'(v);
      end
      nxt_data[64*i +: 64] = d;
      if ($urandom_range(0, 1) == 1) nxt_key[8*i +: 8] = d[8*$urandom_range(0, 7) +: 8];
      else nxt_key[8*i +: 8] = 8'($urandom_range(0, 255));
   endtask

   task automatic engine_update();
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_rdy   = 1'b1;
            eng_out   = eng_res[7:0];
            eng_valid = eng_res[8];
         end
      end else if (eng_en && eng_mode == 0) begin
         busy_len = (eng_lat_cfg > 0) ? eng_lat_cfg : $urandom_range(1, 4);
         eng_res  = eng_search(eng_data, eng_X);
         eng_rdy  = 1'b0;
         eng_cnt  = busy_len + 1;
      end else if (eng_en && eng_mode == 2) begin
         eng_rdy = 1'b0;
      end else if (eng_mode != 2) begin
         eng_rdy = 1'b1;
      end
   endtask

   task automatic monitor();
      int          w;
      rec_t        r;
      logic [8:0]  s;
      logic [7:0]  eo;
      logic        ef;
      logic [NUM_REQ-1:0] exp_rdy;
      chk("busy", busy, !ref_idle);
      chk("eng_en", eng_en, ref_issue);
      ref_issue = 1'b0;
      w = -1;
      if (ref_idle && eng_rdy) w = ref_winner(req_valid, ref_ptr);
      exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk("req_ready", req_ready, exp_rdy);
      if (rsp_valid) begin
         if (q.size() == 0) begin
            chk("rsp_spurious", rsp_valid, 1'b0);
         end else begin
            r = q.pop_front();
            if (r.kind == 1) begin
               eo = 8'h00; ef = 1'b0;
            end else if (r.kind == 2) begin
               eo = 8'hFF; ef = 1'b0;
            end else begin
               s = ref_search(r.data, r.key);
               eo = s[7:0]; ef = s[8];
               chk("latency", cyc - r.gcyc, 3 + busy_len);
            end
            chk("rsp_id", rsp_id, r.id);
            chk("rsp_out", rsp_out, eo);
            chk("rsp_found", rsp_found, ef);
            chk("eng_data_stable", eng_data, r.data);
            chk("eng_X_stable", eng_X, r.key);
`ifdef BSARB_TIMEOUT_EN
            chk("err_timeout", err_timeout, r.kind == 2);
`endif
            hold_id = r.id; hold_out = eo; hold_found = ef;
            if (r.kind != 0) ref_err = 1'b1;
         end
         ref_idle = 1'b1;
      end
`ifdef BSARB_TIMEOUT_EN
      else chk("err_timeout_idle", err_timeout, 1'b0);
`endif
      chk("rsp_id_hold", rsp_id, hold_id);
      chk("rsp_out_hold", rsp_out, hold_out);
      chk("rsp_found_hold", rsp_found, hold_found);
      chk("err", err, ref_err);
      if (w >= 0) begin
         q.push_back('{w, req_data[64*w +: 64], req_key[8*w +: 8], cyc, eng_mode});
         glog.push_back(w);
         ngrant++;
         ref_ptr   = (w + 1) % NUM_REQ;
         ref_idle  = 1'b0;
         ref_issue = 1'b1;
         nxt_valid[w] = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      engine_update();
      if (rand_mode) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!nxt_valid[i] && $urandom_range(0, 99) < 30) begin
               gen_slot(i);
               nxt_valid[i] = 1'b1;
            end else if (nxt_valid[i] && $urandom_range(0, 99) < 5) begin
               nxt_valid[i] = 1'b0;
            end
         end
      end
      req_valid = nxt_valid;
      req_data  = nxt_data;
      req_key   = nxt_key;
      #1;
      monitor();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q.size() > 0 || !ref_idle) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   task automatic do_reset(input int ncyc);
      rst_n     = 1'b0;
      eng_rdy   = 1'b1;
      eng_cnt   = 0;
      eng_out   = 8'd0;
      eng_valid = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_eng_en", eng_en, 1'b0);
      chk("rst_eng_data", eng_data, 64'd0);
      chk("rst_eng_X", eng_X, 8'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 2'd0);
      chk("rst_rsp_out", rsp_out, 8'd0);
      chk("rst_rsp_found", rsp_found, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      repeat (ncyc) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid, 1'b0);
      end
      q.delete();
      ref_ptr = 0; ref_idle = 1'b1; ref_issue = 1'b0; ref_err = 1'b0;
      hold_id = 0; hold_out = 8'd0; hold_found = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic request(input int i);
      nxt_valid[i] = 1'b1;
      step();
   endtask

   initial begin
      int n;
      int g0;
      rst_n = 1'b1;
      nxt_valid = '0; nxt_data = '0; nxt_key = '0;
      req_valid = '0; req_data = '0; req_key = '0;
      eng_rdy = 1'b1; eng_out = 8'd0; eng_valid = 1'b0; eng_res = 9'd0;
      #2;
      do_reset(3);

      // Single request, key hit at byte 1.
      nxt_data[63:0] = {8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20};
      nxt_key[7:0]   = 8'd30;
      request(0);
      drain(40);
      chk("t1_id", rsp_id, 2'd0);
      chk("t1_found", rsp_found, 1'b1);
      chk("t1_index", rsp_out, 8'd1);

      // Key miss on requester 2.
      nxt_data[191:128] = {8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20};
      nxt_key[23:16]    = 8'd35;
      request(2);
      drain(40);
      chk("t2_id", rsp_id, 2'd2);
      chk("t2_found", rsp_found, 1'b0);

      // Contention: all four with distinct keys.
      for (int i = 0; i < NUM_REQ; i++) begin
         gen_slot(i);
         nxt_key[8*i +: 8] = nxt_data[64*i + 8*i +: 8];
      end
      g0 = ngrant;
      nxt_valid = 4'b1111;
      n = 0;
      while (ngrant < g0 + 4 && n < 200) begin
         step();
         n++;
      end
      nxt_valid = 4'b0000;
      drain(40);
      chk("t3_grants", ngrant - g0, 4);

      // Pointer wrap: grant 2 moves the pointer to 3, then 4'b1001 gives 3 then 0.
      gen_slot(2);
      request(2);
      drain(40);
      gen_slot(0);
      gen_slot(3);
      nxt_valid = 4'b1001;
      n = 0;
      while (nxt_valid != 4'b0000 && n < 200) begin
         step();
         n++;
      end
      drain(40);
      chk("t4_first", glog[glog.size() - 2], 3);
      chk("t4_second", glog[glog.size() - 1], 0);

      // Randomised traffic.
      rand_mode = 1'b1;
      repeat (400) step();
      rand_mode = 1'b0;
      nxt_valid = 4'b0000;
      drain(60);

      // Asynchronous reset while the engine is still busy.
      eng_lat_cfg = 10;
      gen_slot(1);
      request(1);
      repeat (5) step();
      chk("t6_busy_before", busy, 1'b1);
      #2;
      do_reset(2);
      eng_lat_cfg = 0;
      gen_slot(1);
      request(1);
      drain(40);
      chk("t6_after_id", rsp_id, 2'd1);

      // Engine that never goes busy: busy-wait expiry, sticky err.
      eng_mode = 1;
      gen_slot(3);
      request(3);
      drain(40);
      chk("t7_err", err, 1'b1);
      eng_mode = 0;
      gen_slot(0);
      request(0);
      drain(40);
      chk("t7_err_sticky", err, 1'b1);

`ifdef BSARB_TIMEOUT_EN
      // Engine that never finishes: watchdog response.
      eng_mode = 2;
      gen_slot(2);
      request(2);
      drain(1200);
      chk("t8_out", rsp_out, 8'hFF);
      eng_mode = 0;
      step();
      gen_slot(1);
      request(1);
      drain(40);
`endif

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
